cb_zigzag_serializer: RTL and testbench
=======================================

# cb_zigzag_serializer

Stage directly downstream of `cb_quantizer`: accepts one quantized 8x8 Cb block (signed 11-bit) on a single-cycle `enable` and emits its 64 coefficients serially in JPEG zigzag order, with a valid/ready handshake toward the Cb entropy coder. Replaces the DC coefficient with its DPCM differential against the previous block's DC, and signals the block end.

## Interface
- No parameters. Widths are fixed by the pipeline.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-low reset.
- `enable`  in  1  block-present strobe. This is `cb_quantizer.out_enable`.
- `Q[0:7][0:7]`  in  11 signed each  quantized block. Valid only in the `enable` cycle.
- `dc_restart`  in  1  DC predictor clear. Sampled only with an accepted `enable`.
- `in_ready`  out  1  block can be accepted this cycle.
- `coef_out`  out  12 signed  zigzag coefficient. Index 0 is the DC differential.
- `coef_idx`  out  6  zigzag index of `coef_out`, 0..63.
- `coef_valid`  out  1  `coef_out`, `coef_idx` and `coef_last` are valid.
- `coef_ready`  in  1  downstream accepts.
- `coef_last`  out  1  high with index 63.
- `overrun`  out  1  sticky. Set when a block was dropped.

## Operation
- Two states: IDLE and SCAN.
- IDLE:
  - `in_ready` = 1.
  - On `enable`: latch all 64 coefficients into the block buffer.
  - Latch `pred` = `dc_restart` ? 0 : `prev_dc`.
  - Set idx = 0 and go to SCAN.
- SCAN:
  - `coef_valid` = 1.
  - idx 0: `coef_out` = sign-extended `buf[0][0]` − `pred`. Range is −2047..2047, so no overflow in 12 bits.
  - idx k > 0: `coef_out` = sign-extend(`buf[ZZ[k]/8][ZZ[k]%8]`).
  - `coef_idx` = idx. `coef_last` = (idx == 63).
- Transfer happens on `coef_valid && coef_ready`, then idx increments.
  - A transfer at idx 63 also sets `prev_dc` ← `buf[0][0]` and returns the state to IDLE.
- Stall (`coef_ready` = 0): every output holds its value. No change is permitted while valid is high and ready is low.
- `enable` while in SCAN: the block is dropped, `overrun` ← 1, and the stream in progress is unaffected.
  - `overrun` clears only on reset.
- ZZ is the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 1. This holds only while `rst` is high; during reset all outputs are 0.
  - `coef_valid` = 0, `coef_last` = 0, `coef_out` = 0, `coef_idx` = 0.
  - `overrun` = 0, `prev_dc` = 0.
- Latency:
  - `enable` sampled at edge N; `coef_valid` is high from cycle N+1.
  - With `coef_ready` held at 1: indices 0..63 appear on consecutive cycles N+1..N+64.
  - IDLE is re-entered at N+65. Minimum block period is 65 cycles.
- `in_ready` is registered and equals (state == IDLE). An `enable` in the same cycle as the idx-63 transfer counts as an overrun.
- All outputs are registered or decoded from registers only. There is no combinational path from `coef_ready` to any output.
- Reset mid-SCAN:
  - Next cycle shows reset values.
  - The partial block is abandoned with no `coef_last`.
  - `prev_dc` = 0.
- `dc_restart` is ignored outside an accepted `enable`.

## Structure
- Shared package `jpeg_zz_pkg`:
  - `ZZ_ORDER[0:63]` constant (6-bit entries).
  - `coef_q_t` (11-bit signed) and `coef_s_t` (12-bit signed) typedefs.
  - State enum `zz_state_e`.
  - The Y and Cr serializers reuse this package.
- One sub-module: `zz_block_buffer`.
  - 64 × 11-bit register array with a parallel write port.
  - One read port addressed by raster index.
  - The top level holds the FSM, idx counter, DC predictor and handshake.

## Test plan
1. Ramp `Q[i][j]` = i*8+j, `prev_dc` 0, `coef_ready` = 1.
   - Outputs are 0,1,8,16,9,2,3,10,…,55,62,63 on cycles N+1..N+64.
   - `coef_last` only at value 63. `in_ready` is back to 1 at N+65.
2. DC DPCM.
   - Block A with `Q[0][0]` = 50 gives first output 50.
   - Block B with `Q[0][0]` = 20 gives first output −30.
   - Block C with `Q[0][0]` = 20 and `dc_restart` = 1 gives first output 20.
3. Extremes.
   - Prev DC 1023, new `Q[0][0]` = −1024: `coef_out` = −2047.
   - AC −1024: `coef_out` = 12'hC00.
   - AC 1023: `coef_out` = 12'h3FF.
4. Backpressure: `coef_ready` pattern 1,0,0,1 repeated.
   - Outputs are stable during each 0.
   - Exactly 64 transfers, indices strictly 0..63 with no skip or repeat.
5. Overrun: `enable` pulsed at idx 10.
   - The block is dropped and `overrun` rises next cycle.
   - The current stream completes unchanged. `overrun` stays 1 until reset.
6. Reset asserted at idx 20.
   - Next cycle `coef_valid` = 0 and `in_ready` = 0; `in_ready` returns to 1 after release.
   - The next block with `Q[0][0]` = 7 emits 7 at idx 0, because `prev_dc` was cleared.

Source files
------------

// File: rtl/jpeg_zz_pkg.sv
// Shared definitions for the Y/Cb/Cr zigzag serializers.
//   coef_q_t   : quantized coefficient, 11-bit signed
//   coef_s_t   : serialized coefficient / DC differential, 12-bit signed
//   zz_state_e : serializer FSM states
//   ZZ_ORDER   : JPEG zigzag position k -> raster index (row*8 + col)
//   sext_coef  : sign-extend a quantized coefficient to serializer width
package jpeg_zz_pkg;

  typedef logic signed [10:0] coef_q_t;
  typedef logic signed [11:0] coef_s_t;

  typedef enum logic {
    ZZ_IDLE = 1'b0,
    ZZ_SCAN = 1'b1
  } zz_state_e;

  localparam logic [5:0] ZZ_ORDER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic coef_s_t sext_coef(input coef_q_t v);
    return coef_s_t'(v);
  endfunction

endpackage

// File: rtl/zz_block_buffer.sv
// 8x8 block store for the zigzag serializer.
//   clk       : clock
//   i_wr_en   : write the whole block in one cycle
//   i_wr_data : block to store, [row][col]
//   i_rd_addr : raster read address (row*8 + col)
//   o_rd_data : coefficient at i_rd_addr (combinational read)
module zz_block_buffer
  import jpeg_zz_pkg::*;
(
  input  logic    clk,
  input  logic    i_wr_en,
  input  coef_q_t i_wr_data [0:7][0:7],
  input  logic [5:0] i_rd_addr,
  output coef_q_t o_rd_data
);

  coef_q_t r_mem [0:7][0:7];

  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr[5:3]][i_rd_addr[2:0]];

endmodule

// File: rtl/cb_zigzag_serializer.sv
// Cb zigzag serializer: captures a quantized 8x8 block on a single-cycle
// enable and streams its 64 coefficients in JPEG zigzag order over a
// valid/ready handshake. Coefficient 0 is replaced by its DPCM differential
// against the previous completed block's DC.
//   clk        : clock
//   rst        : synchronous active-low reset
//   enable     : block-present strobe
//   Q          : quantized block, valid only with enable
//   dc_restart : clear DC predictor (sampled with accepted enable)
//   in_ready   : a block can be accepted (registered)
//   coef_out   : zigzag coefficient (idx 0 = DC differential)
//   coef_idx   : zigzag index of coef_out
//   coef_valid : coef_out/coef_idx/coef_last valid
//   coef_ready : downstream accepts
//   coef_last  : high with index 63
//   overrun    : sticky, a block arrived while streaming and was dropped
module cb_zigzag_serializer
  import jpeg_zz_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  coef_q_t    Q [0:7][0:7],
  input  logic       dc_restart,
  output logic       in_ready,
  output coef_s_t    coef_out,
  output logic [5:0] coef_idx,
  output logic       coef_valid,
  input  logic       coef_ready,
  output logic       coef_last,
  output logic       overrun
);

  zz_state_e  r_state;
  logic [5:0] r_idx;
  coef_q_t    r_prev_dc;
  coef_q_t    r_cur_dc;
  coef_s_t    r_coef;
  logic       r_valid;
  logic       r_last;
  logic       r_in_ready;
  logic       r_overrun;

  logic       w_accept;
  logic       w_xfer;
  logic [5:0] w_next_idx;
  logic [5:0] w_rd_addr;
  coef_q_t    w_rd_data;
  coef_q_t    w_pred;
  coef_s_t    w_dc_diff;

  assign w_accept   = (r_state == ZZ_IDLE) && enable;
  assign w_xfer     = r_valid && coef_ready;
  assign w_next_idx = r_idx + 6'd1;
  // The buffer is read one position ahead so the next coefficient can be
  // registered on the transfer edge; idx 0 bypasses the buffer entirely.
  assign w_rd_addr  = ZZ_ORDER[w_next_idx];
  assign w_pred     = dc_restart ? '0 : r_prev_dc;
  assign w_dc_diff  = sext_coef(Q[0][0]) - sext_coef(w_pred);

  zz_block_buffer u_buf (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_data (Q),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ZZ_IDLE;
      r_idx      <= '0;
      r_prev_dc  <= '0;
      r_cur_dc   <= '0;
      r_coef     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_in_ready <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if ((r_state == ZZ_SCAN) && enable)
        r_overrun <= 1'b1;

      case (r_state)
        ZZ_IDLE: begin
          r_in_ready <= 1'b1;
          if (enable) begin
            r_state    <= ZZ_SCAN;
            r_in_ready <= 1'b0;
            r_valid    <= 1'b1;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_coef     <= w_dc_diff;
            r_cur_dc   <= Q[0][0];
          end
        end
        ZZ_SCAN: begin
          if (w_xfer) begin
            if (r_idx == 6'd63) begin
              r_state    <= ZZ_IDLE;
              r_in_ready <= 1'b1;
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
              r_idx      <= '0;
              r_coef     <= '0;
              r_prev_dc  <= r_cur_dc;
            end else begin
              r_idx  <= w_next_idx;
              r_coef <= sext_coef(w_rd_data);
              r_last <= (w_next_idx == 6'd63);
            end
          end
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign coef_out   = r_coef;
  assign coef_idx   = r_idx;
  assign coef_valid = r_valid;
  assign coef_last  = r_last;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_cb_zigzag_serializer.sv
module tb_cb_zigzag_serializer;
  import jpeg_zz_pkg::coef_q_t;
  import jpeg_zz_pkg::coef_s_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  coef_q_t    Q [0:7][0:7];
  logic       dc_restart;
  logic       in_ready;
  coef_s_t    coef_out;
  logic [5:0] coef_idx;
  logic       coef_valid;
  logic       coef_ready;
  logic       coef_last;
  logic       overrun;

  always #5 clk = ~clk;

  cb_zigzag_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .Q          (Q),
    .dc_restart (dc_restart),
    .in_ready   (in_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .overrun    (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model: zigzag walk derived from the anti-diagonal rule,
  // DC predictor and sticky overrun flag.
  int      zr [64];
  int      zc [64];
  coef_q_t blk [0:7][0:7];
  int      expq [64];
  int      m_prev_dc = 0;
  int      m_ovr = 0;

  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zr[k] = r; zc[k] = s - r; k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zr[k] = r; zc[k] = s - r; k++; end
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        blk[r][c] = coef_q_t'($urandom);
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready
  task automatic run_block(input bit restart, input int mode,
                           input int ovr_at, input int rst_at);
    int  pred;
    int  k;
    int  cyc;
    int  wait_cyc;
    bit  rdy;
    bit  ovr_drive;
    bit  ovr_done;
    wait_cyc = 0;
    while (in_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("in_ready_before_block", in_ready, 1);
    Q          = blk;
    enable     = 1'b1;
    dc_restart = restart;
    pred = restart ? 0 : m_prev_dc;
    for (int i = 0; i < 64; i++)
      expq[i] = (i == 0) ? int'(blk[0][0]) - pred : int'(blk[zr[i]][zc[i]]);
    @(negedge clk);
    enable     = 1'b0;
    dc_restart = 1'($urandom_range(0, 1));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        Q[r][c] = coef_q_t'($urandom);
    k = 0;
    cyc = 0;
    ovr_done = 1'b0;
    while (k < 64 && cyc < 1000) begin
      check("coef_valid", coef_valid, 1);
      check("coef_idx", coef_idx, k);
      check("coef_out", coef_out, expq[k]);
      check("coef_last", coef_last, (k == 63) ? 1 : 0);
      check("in_ready_scan", in_ready, 0);
      check("overrun", overrun, m_ovr);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      coef_ready = rdy;
      ovr_drive = (k == ovr_at) && !ovr_done;
      if (ovr_drive) begin
        ovr_done = 1'b1;
        enable = 1'b1;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            Q[r][c] = coef_q_t'($urandom);
      end
      if (k == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        check("rst_coef_valid", coef_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_coef_last", coef_last, 0);
        check("rst_coef_out", coef_out, 0);
        check("rst_coef_idx", coef_idx, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        coef_ready = 1'b1;
        m_prev_dc = 0;
        m_ovr = 0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", coef_valid, 0);
        return;
      end
      @(negedge clk);
      enable = 1'b0;
      if (ovr_drive) m_ovr = 1;
      if (rdy) k++;
      cyc++;
    end
    if (k < 64) check("stream_timeout", k, 64);
    check("end_coef_valid", coef_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_coef_last", coef_last, 0);
    check("end_overrun", overrun, m_ovr);
    m_prev_dc = int'(blk[0][0]);
  endtask

  initial begin
    build_zz();
    rst        = 1'b0;
    enable     = 1'b0;
    dc_restart = 1'b0;
    coef_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        Q[r][c] = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_coef_valid", coef_valid, 0);
    check("reset_coef_out", coef_out, 0);
    check("reset_coef_idx", coef_idx, 0);
    check("reset_coef_last", coef_last, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);

    // Ramp block, full throughput
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        blk[r][c] = coef_q_t'(r * 8 + c);
    run_block(1'b0, 0, -1, -1);

    // DC DPCM: 50, then 20 (-30), then 20 with restart (20)
    fill_random(); blk[0][0] = 11'sd50;
    run_block(1'b0, 0, -1, -1);
    fill_random(); blk[0][0] = 11'sd20;
    run_block(1'b0, 2, -1, -1);
    fill_random(); blk[0][0] = 11'sd20;
    run_block(1'b1, 0, -1, -1);

    // Extremes
    fill_random(); blk[0][0] = 11'sd1023;
    run_block(1'b1, 0, -1, -1);
    fill_random(); blk[0][0] = -11'sd1024; blk[0][1] = -11'sd1024; blk[7][7] = 11'sd1023;
    run_block(1'b0, 0, -1, -1);

    // Backpressure 1,0,0,1
    fill_random();
    run_block(1'b0, 1, -1, -1);

    // Random blocks with random backpressure and restarts
    for (int b = 0; b < 4; b++) begin
      fill_random();
      run_block(1'($urandom_range(0, 1)), 2, -1, -1);
    end

    // Overrun at idx 10, then a following block with overrun still sticky
    fill_random();
    run_block(1'b0, 2, 10, -1);
    fill_random();
    run_block(1'b0, 0, -1, -1);

    // Reset at idx 20, then Q[0][0]=7 with enable coinciding with idx-63 transfer
    fill_random();
    run_block(1'b0, 0, -1, 20);
    fill_random(); blk[0][0] = 11'sd7;
    run_block(1'b0, 1, 63, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
